mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one main-memory port between
// the I-side and D-side cache controllers, with a grant timeout.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 28,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_mem_read,
    input  logic                  p0_mem_write,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_mem_ready,
    input  logic                  p1_mem_read,
    input  logic                  p1_mem_write,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic                  p1_mem_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    output logic [1:0]            grant,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state_q;
    state_t        state_d;
    logic          last_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    logic act0;
    logic act1;
    logic own_act;
    logic rel;
    logic to;

    assign act0    = p0_mem_read | p0_mem_write;
    assign act1    = p1_mem_read | p1_mem_write;
    assign own_act = (state_q == SERVE1) ? act1 : act0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE || rel)
                cnt_q <= '0;
            else if (cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
            if (rel)
                last_q <= (state_q == SERVE1);
            if (to)
                err_q <= 1'b1;
        end
    end

    // Completion beats a requester leaving, which beats the timeout.
    always_comb begin
        state_d = state_q;
        rel     = 1'b0;
        to      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (act0 && act1)
                    state_d = last_q ? SERVE0 : SERVE1;
                else if (act0)
                    state_d = SERVE0;
                else if (act1)
                    state_d = SERVE1;
            end
            SERVE0, SERVE1: begin
                if (mem_ready || !own_act) begin
                    rel = 1'b1;
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == LAST) begin
                    rel = 1'b1;
                    to  = 1'b1;
                end
                if (rel)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant        = 2'b00;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        p0_mem_ready = 1'b0;
        p1_mem_ready = 1'b0;
        unique case (state_q)
            SERVE0: begin
                grant        = 2'b01;
                mem_write    = p0_mem_write;
                mem_read     = p0_mem_read & ~p0_mem_write;
                mem_addr     = p0_addr;
                p0_mem_ready = mem_ready;
            end
            SERVE1: begin
                grant        = 2'b10;
                mem_write    = p1_mem_write;
                mem_read     = p1_mem_read & ~p1_mem_write;
                mem_addr     = p1_addr;
                p1_mem_ready = mem_ready;
            end
            default: ;
        endcase
    end

    assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized
// traffic compared with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_mem_read, p0_mem_write;
    logic [AW-1:0] p0_addr;
    logic          p0_mem_ready;
    logic          p1_mem_read, p1_mem_write;
    logic [AW-1:0] p1_addr;
    logic          p1_mem_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [1:0]    grant;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, cycles spent waiting,
    // who was served last, sticky error, completion events.
    int m_owner;
    int m_wait;
    int m_last;
    bit m_err;
    bit m_done0, m_done1;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .p0_mem_read(p0_mem_read), .p0_mem_write(p0_mem_write),
        .p0_addr(p0_addr), .p0_mem_ready(p0_mem_ready),
        .p1_mem_read(p1_mem_read), .p1_mem_write(p1_mem_write),
        .p1_addr(p1_addr), .p1_mem_ready(p1_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit a0, a1, own;
        a0 = p0_mem_read | p0_mem_write;
        a1 = p1_mem_read | p1_mem_write;
        m_done0 = 0;
        m_done1 = 0;
        if (rst) begin
            m_owner = 0; m_wait = 0; m_last = 1; m_err = 0;
        end else if (m_owner == 0) begin
            m_wait = 0;
            if (a0 && a1) m_owner = (m_last == 1) ? 1 : 2;
            else if (a0) m_owner = 1;
            else if (a1) m_owner = 2;
        end else begin
            own = (m_owner == 1) ? a0 : a1;
            if (mem_ready) begin
                if (m_owner == 1) m_done0 = 1; else m_done1 = 1;
                m_last = m_owner - 1; m_owner = 0;
            end else if (!own) begin
                m_last = m_owner - 1; m_owner = 0;
            end else if (m_wait + 1 == T) begin
                m_err = 1; m_last = m_owner - 1; m_owner = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        p0_mem_read = 0; p0_mem_write = 0; p0_addr = '0;
        p1_mem_read = 0; p1_mem_write = 0; p1_addr = '0;
        mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        mem_ready = 1;
        #1;
        checks++;
        if ({grant, mem_read, mem_write, mem_addr, p0_mem_ready,
             p1_mem_ready, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_idle: grant=%b rd=%b wr=%b addr=%h r0=%b r1=%b err=%b want all 0",
                     grant, mem_read, mem_write, mem_addr, p0_mem_ready,
                     p1_mem_ready, timeout_err);
        end
        tick();
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL idle_ignores_ready: grant=%b want 00", grant);
        end
        mem_ready = 0;
    endtask

    task automatic test_single();
        idle_inputs();
        do_reset();
        p0_mem_read = 1; p0_addr = 28'h0000ABC;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL single_c0: grant=%b want 00", grant);
        end
        tick();
        #1;
        checks++;
        if (grant !== 2'b01 || mem_read !== 1 || mem_write !== 0 ||
            mem_addr !== 28'h0000ABC) begin
            errors++;
            $display("FAIL single_c1: grant=%b rd=%b wr=%b addr=%h want 01 1 0 0000abc",
                     grant, mem_read, mem_write, mem_addr);
        end
        tick(); tick(); tick();
        mem_ready = 1;
        #1;
        checks++;
        if (p0_mem_ready !== 1 || p1_mem_ready !== 0 || grant !== 2'b01) begin
            errors++;
            $display("FAIL single_c4: r0=%b r1=%b grant=%b want 1 0 01",
                     p0_mem_ready, p1_mem_ready, grant);
        end
        tick();
        mem_ready = 0; p0_mem_read = 0;
        #1;
        checks++;
        if (grant !== 2'b00 || mem_read !== 0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL single_c5: grant=%b rd=%b addr=%h want 00 0 0",
                     grant, mem_read, mem_addr);
        end
    endtask

    task automatic test_tie();
        idle_inputs();
        p0_mem_read = 1; p0_addr = 28'h1111;
        p1_mem_read = 1; p1_addr = 28'h2222;
        do_reset();
        tick();
        #1;
        checks++;
        if (grant !== 2'b01 || mem_addr !== 28'h1111) begin
            errors++;
            $display("FAIL tie_first: grant=%b addr=%h want 01 0001111",
                     grant, mem_addr);
        end
        mem_ready = 1;
        tick();
        mem_ready = 0; p0_mem_read = 0;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL tie_gap: grant=%b want 00", grant);
        end
        tick();
        #1;
        checks++;
        if (grant !== 2'b10 || mem_addr !== 28'h2222) begin
            errors++;
            $display("FAIL tie_second: grant=%b addr=%h want 10 0002222",
                     grant, mem_addr);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp;
        idle_inputs();
        p0_mem_write = 1; p1_mem_read = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            #1;
            checks++;
            if (grant !== exp) begin
                errors++;
                $display("FAIL alternate_%0d: grant=%b want %b", i, grant, exp);
            end
            mem_ready = 1;
            tick();
            mem_ready = 0;
        end
    endtask

    task automatic test_timeout();
        idle_inputs();
        do_reset();
        p1_mem_write = 1; p1_addr = 28'h0BEEF;
        tick();
        for (int i = 0; i < T; i++) begin
            #1;
            checks++;
            if (grant !== 2'b10 || timeout_err !== 0) begin
                errors++;
                $display("FAIL timeout_wait_%0d: grant=%b err=%b want 10 0",
                         i, grant, timeout_err);
            end
            tick();
        end
        p1_mem_write = 0;
        #1;
        checks++;
        if (grant !== 2'b00 || timeout_err !== 1 || p1_mem_ready !== 0) begin
            errors++;
            $display("FAIL timeout_abort: grant=%b err=%b r1=%b want 00 1 0",
                     grant, timeout_err, p1_mem_ready);
        end
        tick(); tick(); tick();
        #1;
        checks++;
        if (timeout_err !== 1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b want 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        do_reset();
        p1_mem_write = 1; p1_addr = 28'h0C0DE;
        for (int i = 0; i < T + 3; i++) tick();
        #1;
        checks++;
        if (grant !== 2'b10 || mem_write !== 1 || timeout_err !== 1) begin
            errors++;
            $display("FAIL rstmid_pre: grant=%b wr=%b err=%b want 10 1 1",
                     grant, mem_write, timeout_err);
        end
        p0_mem_read = 1;
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (grant !== 2'b00 || mem_write !== 0 || timeout_err !== 0) begin
            errors++;
            $display("FAIL rstmid_post: grant=%b wr=%b err=%b want 00 0 0",
                     grant, mem_write, timeout_err);
        end
        tick();
        #1;
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_tie: grant=%b want 01", grant);
        end
    endtask

    task automatic test_write_wins();
        idle_inputs();
        do_reset();
        p0_mem_read = 1; p0_mem_write = 1; p0_addr = 28'h0FACE;
        p1_mem_read = 1; p1_addr = 28'h0D00D;
        tick();
        #1;
        checks++;
        if (mem_write !== 1 || mem_read !== 0 || mem_addr !== 28'h0FACE) begin
            errors++;
            $display("FAIL write_wins: rd=%b wr=%b addr=%h want 0 1 000face",
                     mem_read, mem_write, mem_addr);
        end
        mem_ready = 1;
        #1;
        checks++;
        if (p1_mem_ready !== 0 || p0_mem_ready !== 1) begin
            errors++;
            $display("FAIL other_ready: r0=%b r1=%b want 1 0",
                     p0_mem_ready, p1_mem_ready);
        end
        tick();
        mem_ready = 0;
    endtask

    task automatic test_random();
        logic [1:0]    e_grant;
        logic          e_rd, e_wr, e_r0, e_r1;
        logic [AW-1:0] e_addr;
        logic [1:0]    rw;
        idle_inputs();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (p0_mem_read | p0_mem_write) begin
                if (m_done0 || $urandom % 20 == 0) begin
                    p0_mem_read = 0; p0_mem_write = 0;
                end
            end else if ($urandom % 10 < 4) begin
                rw = 2'($urandom_range(1, 3));
                p0_mem_read = rw[0]; p0_mem_write = rw[1];
                p0_addr = AW'($urandom);
            end
            if (p1_mem_read | p1_mem_write) begin
                if (m_done1 || $urandom % 20 == 0) begin
                    p1_mem_read = 0; p1_mem_write = 0;
                end
            end else if ($urandom % 10 < 4) begin
                rw = 2'($urandom_range(1, 3));
                p1_mem_read = rw[0]; p1_mem_write = rw[1];
                p1_addr = AW'($urandom);
            end
            mem_ready = ($urandom % 4 == 0);
            rst = ($urandom % 200 == 0);
            e_grant = 2'b00; e_rd = 0; e_wr = 0; e_addr = '0;
            e_r0 = 0; e_r1 = 0;
            if (m_owner == 1) begin
                e_grant = 2'b01; e_wr = p0_mem_write;
                e_rd = p0_mem_read & ~p0_mem_write;
                e_addr = p0_addr; e_r0 = mem_ready;
            end else if (m_owner == 2) begin
                e_grant = 2'b10; e_wr = p1_mem_write;
                e_rd = p1_mem_read & ~p1_mem_write;
                e_addr = p1_addr; e_r1 = mem_ready;
            end
            #1;
            checks++;
            if ({grant, mem_read, mem_write, mem_addr, p0_mem_ready,
                 p1_mem_ready, timeout_err} !==
                {e_grant, e_rd, e_wr, e_addr, e_r0, e_r1, m_err}) begin
                errors++;
                $display("FAIL random_c%0d: got g=%b rd=%b wr=%b a=%h r0=%b r1=%b err=%b want g=%b rd=%b wr=%b a=%h r0=%b r1=%b err=%b",
                         c, grant, mem_read, mem_write, mem_addr,
                         p0_mem_ready, p1_mem_ready, timeout_err,
                         e_grant, e_rd, e_wr, e_addr, e_r0, e_r1, m_err);
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m_owner = 0; m_wait = 0; m_last = 1; m_err = 0;
        m_done0 = 0; m_done1 = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_timeout();
        test_reset_mid();
        test_write_wins();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
